audio_arbiter: RTL and testbench
================================

Name: audio_arbiter

Overview:
- Shares the single tone generator (buzzer/PWM path) between the four background-music requests and two short sound effects.
- The background requests are music[3:0]: INIT, PLAY, WIN and LOSS, one-hot from the top level.
- The sound effects are hit and miss, each a pulse from the game controller.
- Each cycle the block picks the source, steps a note index on every tempo beat, and drives a registered note code to the tone generator.

Parameters:
- TRACK_LEN, 16: notes per background track; index wraps or stops at TRACK_LEN-1.
- SFX_LEN, 4: beats an effect holds the tone generator.
- NOTE_W, 5: note code width; code 0 means silence.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- music_req  input  4  one-hot background request; bit0 INIT, bit1 PLAY, bit2 WIN, bit3 LOSS
- sfx_hit  input  1  one-cycle pulse, hit effect request
- sfx_miss  input  1  one-cycle pulse, miss effect request
- beat_tick  input  1  one-cycle tempo strobe
- note_code  output  NOTE_W  registered note to the tone generator; 0 means silence
- note_valid  output  1  high when note_code is non-silent
- cur_track  output  2  encoded track currently owning the tone generator
- sfx_active  output  1  high while an effect owns the tone generator
- track_done  output  1  high while a WIN or LOSS track has finished and is holding silence

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; note index 0; sfx counter 0; pending track cleared; latched effect cleared.
- States: IDLE, BGM, SFX, HOLD.
- Track decode:
  - Exactly one bit of music_req set → valid request, encoded 0..3.
  - Zero bits or several bits set → invalid. Treat as a request for silence: go to IDLE on the next beat_tick.
- Track change:
  - Any cycle where the encoded request differs from cur_track latches it as pending.
  - The pending track is applied on the next beat_tick: cur_track updates, index resets to 0, state goes to BGM.
  - The first note of the new track appears on that same beat (1-cycle registered latency after beat_tick).
- BGM state:
  - On each beat_tick, note_code = rom(cur_track, index), then index increments.
  - INIT and PLAY wrap from TRACK_LEN-1 to 0.
  - WIN and LOSS: after index TRACK_LEN-1 is played, the next beat_tick moves to HOLD.
- HOLD state:
  - note_code = 0, track_done = 1.
  - Stays in HOLD until a different track is applied, then track_done clears.
- Effect start:
  - An sfx pulse in BGM, HOLD or IDLE moves to SFX on the next clk edge (latency 1, not beat-aligned).
  - Entry to SFX: sfx_active = 1, sfx counter = SFX_LEN, note_code = effect note 0 on that cycle.
  - The background index and state are frozen (saved).
- SFX state:
  - Each beat_tick decrements the counter and advances the effect note.
  - When the counter reaches 0 on a beat_tick, restore the saved state and index. The background note resumes on that same beat without skipping.
  - A pending track change is held during SFX and applied on the first beat after the effect ends.
- Effect priority: miss > hit.
  - sfx_hit and sfx_miss in the same cycle → miss is taken; the hit is dropped.
  - A new request during SFX with priority ≥ the running effect restarts the counter at SFX_LEN with the new effect.
  - A hit during a miss effect is ignored.
- Simultaneous events:
  - beat_tick together with an sfx pulse → the effect wins. The background index does not advance on that beat.
  - beat_tick together with a track change → the change is latched as pending and applied on the following beat.
- rst mid-operation clears everything immediately, regardless of state.
- note_valid = (note_code != 0), registered together with note_code.

Decomposition:
- Shared package holds:
  - track encodings TRK_INIT=0, TRK_PLAY=1, TRK_WIN=2, TRK_LOSS=3
  - state encodings
  - effect IDs SFX_HIT and SFX_MISS
  - NOTE_SILENT=0
- One sub-module: audio_note_rom, a combinational lookup of (track or effect select, index) → note code.
- The arbiter FSM, counters and saved context stay in audio_arbiter.

Test Plan:
- Reset release with music_req=4'b0001 → on beat 1: cur_track=0, note_code=rom(0,0); after 16 beats the index wraps and rom(0,0) repeats.
- music_req switches 0001→0100 mid-beat → cur_track stays 0 until the next beat_tick, then becomes 2 with index 0. After 16 beats: HOLD, note_code=0, track_done=1.
- PLAY at index 5, sfx_hit pulse:
  - next cycle sfx_active=1, note_code=hit note 0
  - after 4 beats sfx_active=0 and note_code=rom(1,5)
- sfx_hit and sfx_miss in the same cycle → miss effect plays. sfx_hit 2 beats into a miss is ignored, and the effect still ends 4 beats after it started.
- Track change requested during SFX → cur_track unchanged until the effect ends; applied on the following beat with index 0.
- music_req=4'b0110 → IDLE after the next beat, note_valid=0. rst asserted mid-SFX → all outputs 0 asynchronously.

Source files
------------

// File: rtl/audio_arbiter_pkg.sv
// Shared encodings for the audio arbiter: tracks, FSM states, effect IDs.
package audio_arbiter_pkg;

  localparam int NOTE_SILENT = 0;

  typedef enum logic [1:0] {
    TRK_INIT = 2'd0,
    TRK_PLAY = 2'd1,
    TRK_WIN  = 2'd2,
    TRK_LOSS = 2'd3
  } track_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BGM  = 2'd1,
    ST_SFX  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Ordered so that a numerically larger ID has higher priority.
  typedef enum logic {
    SFX_HIT  = 1'b0,
    SFX_MISS = 1'b1
  } sfx_e;

  // WIN and LOSS play once and then hold silence; INIT and PLAY loop.
  function automatic logic is_one_shot(input track_e t);
    return (t == TRK_WIN) || (t == TRK_LOSS);
  endfunction

endpackage

// File: rtl/audio_arbiter_note_rom.sv
// Combinational note table: background melodies per track and short effect jingles.
module audio_note_rom
  import audio_arbiter_pkg::*;
#(
  parameter int NOTE_W = 5,
  parameter int IDX_W  = 4
) (
  input  logic              is_sfx,
  input  track_e            track,
  input  sfx_e              effect,
  input  logic [IDX_W-1:0]  idx,
  output logic [NOTE_W-1:0] note
);

  logic [7:0] bgm_s;

  // Melodies are an arithmetic walk mod 23, which leaves the odd rest (code 0) in a track.
  always_comb begin
    bgm_s = (8'(track) * 8'd5 + 8'(idx) * 8'd3 + 8'd1) % 8'd23;
    if (is_sfx) begin
      if (effect == SFX_MISS) begin
        note = NOTE_W'(8'd8 - 8'(idx));
      end else begin
        note = NOTE_W'(8'd24 + 8'(idx));
      end
    end else begin
      note = NOTE_W'(bgm_s);
    end
  end

endmodule

// File: rtl/audio_arbiter.sv
// Arbitrates the tone generator between looping/one-shot background music and
// two prioritised sound effects, stepping notes on the tempo beat.
module audio_arbiter
  import audio_arbiter_pkg::*;
#(
  parameter int TRACK_LEN = 16,
  parameter int SFX_LEN   = 4,
  parameter int NOTE_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        music_req,
  input  logic              sfx_hit,
  input  logic              sfx_miss,
  input  logic              beat_tick,
  output logic [NOTE_W-1:0] note_code,
  output logic              note_valid,
  output logic [1:0]        cur_track,
  output logic              sfx_active,
  output logic              track_done
);

  localparam int IDX_W = $clog2(TRACK_LEN);
  localparam int POS_W = IDX_W + 1;
  localparam int CNT_W = $clog2(SFX_LEN + 1);
  localparam logic [POS_W-1:0]  POS_ZERO = POS_W'(0);
  localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(TRACK_LEN - 1);
  localparam logic [POS_W-1:0]  POS_END  = POS_W'(TRACK_LEN);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(SFX_LEN);
  localparam logic [IDX_W-1:0]  IDX_ZERO = IDX_W'(0);
  localparam logic [NOTE_W-1:0] SILENT   = NOTE_W'(NOTE_SILENT);

  state_e             state_r, saved_state_r;
  track_e             cur_track_r, pend_track_r;
  sfx_e               fx_r;
  logic [POS_W-1:0]   pos_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               pend_r, pend_tone_r;
  logic [NOTE_W-1:0]  note_r;
  logic               note_valid_r, sfx_active_r, track_done_r;

  logic               req_valid_s;
  track_e             req_track_s;
  sfx_e               fx_req_id_s;
  logic               fx_take_s;
  state_e             bg_state_s;
  logic               apply_s, apply_tone_s;
  logic [NOTE_W-1:0]  bg_note_s, fx_note_s;
  logic [IDX_W-1:0]   fx_idx_s;

  state_e             step_state_s;
  track_e             step_track_s;
  logic [POS_W-1:0]   step_pos_s;
  logic [NOTE_W-1:0]  step_note_s;
  logic               step_done_s;

  state_e             state_nx_s, saved_nx_s;
  track_e             track_nx_s;
  sfx_e               fx_nx_s;
  logic [POS_W-1:0]   pos_nx_s;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic [NOTE_W-1:0]  note_nx_s;
  logic               done_nx_s, active_nx_s, pend_nx_s;

  // Anything other than exactly one request bit is a request for silence.
  always_comb begin
    req_valid_s = 1'b1;
    req_track_s = TRK_INIT;
    case (music_req)
      4'b0001: req_track_s = TRK_INIT;
      4'b0010: req_track_s = TRK_PLAY;
      4'b0100: req_track_s = TRK_WIN;
      4'b1000: req_track_s = TRK_LOSS;
      default: req_valid_s = 1'b0;
    endcase
  end

  assign fx_req_id_s  = sfx_miss ? SFX_MISS : SFX_HIT;
  assign fx_take_s    = (sfx_hit | sfx_miss) && ((state_r != ST_SFX) || (fx_req_id_s >= fx_r));
  assign bg_state_s   = (state_r == ST_SFX) ? saved_state_r : state_r;
  assign apply_s      = pend_r && (state_r != ST_SFX);
  assign apply_tone_s = apply_s && pend_tone_r;
  assign fx_idx_s     = fx_take_s ? IDX_ZERO : IDX_W'(CNT_FULL - cnt_r + CNT_ONE);

  audio_note_rom #(.NOTE_W(NOTE_W), .IDX_W(IDX_W)) u_bg_rom (
    .is_sfx (1'b0),
    .track  (apply_tone_s ? pend_track_r : cur_track_r),
    .effect (SFX_HIT),
    .idx    (apply_tone_s ? IDX_ZERO : pos_r[IDX_W-1:0]),
    .note   (bg_note_s)
  );

  audio_note_rom #(.NOTE_W(NOTE_W), .IDX_W(IDX_W)) u_fx_rom (
    .is_sfx (1'b1),
    .track  (TRK_INIT),
    .effect (fx_take_s ? fx_req_id_s : fx_r),
    .idx    (fx_idx_s),
    .note   (fx_note_s)
  );

  // One background beat; also used on the beat that ends an effect, where pending changes wait.
  always_comb begin
    step_state_s = bg_state_s;
    step_track_s = cur_track_r;
    step_pos_s   = pos_r;
    step_note_s  = SILENT;
    step_done_s  = 1'b0;
    if (apply_s) begin
      if (pend_tone_r) begin
        step_state_s = ST_BGM;
        step_track_s = pend_track_r;
        step_note_s  = bg_note_s;
        step_pos_s   = POS_ONE;
      end else begin
        step_state_s = ST_IDLE;
        step_pos_s   = POS_ZERO;
      end
    end else begin
      case (bg_state_s)
        ST_BGM: begin
          if (is_one_shot(cur_track_r) && (pos_r == POS_END)) begin
            step_state_s = ST_HOLD;
            step_done_s  = 1'b1;
          end else begin
            step_note_s = bg_note_s;
            if (!is_one_shot(cur_track_r) && (pos_r == POS_LAST)) begin
              step_pos_s = POS_ZERO;
            end else begin
              step_pos_s = pos_r + POS_ONE;
            end
          end
        end
        ST_HOLD: step_done_s = 1'b1;
        default: step_done_s = 1'b0;
      endcase
    end
  end

  // Top-level FSM: effect start/restart beats everything, then beat-driven stepping.
  always_comb begin
    state_nx_s = state_r;
    saved_nx_s = saved_state_r;
    track_nx_s = cur_track_r;
    pos_nx_s   = pos_r;
    cnt_nx_s   = cnt_r;
    fx_nx_s    = fx_r;
    note_nx_s  = note_r;
    done_nx_s  = track_done_r;
    if (fx_take_s) begin
      state_nx_s = ST_SFX;
      saved_nx_s = bg_state_s;
      fx_nx_s    = fx_req_id_s;
      cnt_nx_s   = CNT_FULL;
      note_nx_s  = fx_note_s;
      done_nx_s  = 1'b0;
    end else if (beat_tick) begin
      if ((state_r == ST_SFX) && (cnt_r > CNT_ONE)) begin
        cnt_nx_s  = cnt_r - CNT_ONE;
        note_nx_s = fx_note_s;
      end else begin
        state_nx_s = step_state_s;
        track_nx_s = step_track_s;
        pos_nx_s   = step_pos_s;
        note_nx_s  = step_note_s;
        done_nx_s  = step_done_s;
        cnt_nx_s   = CNT_ZERO;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end
  end

  // Pending change is judged against the background context as it will be after this edge.
  always_comb begin
    active_nx_s = (state_nx_s == ST_SFX) ? (saved_nx_s != ST_IDLE) : (state_nx_s != ST_IDLE);
    if (req_valid_s) begin
      pend_nx_s = !active_nx_s || (req_track_s != track_nx_s);
    end else begin
      pend_nx_s = active_nx_s;
    end
  end

  // State, context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      saved_state_r <= ST_IDLE;
      cur_track_r   <= TRK_INIT;
      pend_track_r  <= TRK_INIT;
      fx_r          <= SFX_HIT;
      pos_r         <= POS_ZERO;
      cnt_r         <= CNT_ZERO;
      pend_r        <= 1'b0;
      pend_tone_r   <= 1'b0;
      note_r        <= SILENT;
      note_valid_r  <= 1'b0;
      sfx_active_r  <= 1'b0;
      track_done_r  <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      saved_state_r <= saved_nx_s;
      cur_track_r   <= track_nx_s;
      pend_track_r  <= req_track_s;
      fx_r          <= fx_nx_s;
      pos_r         <= pos_nx_s;
      cnt_r         <= cnt_nx_s;
      pend_r        <= pend_nx_s;
      pend_tone_r   <= req_valid_s;
      note_r        <= note_nx_s;
      note_valid_r  <= (note_nx_s != SILENT);
      sfx_active_r  <= (state_nx_s == ST_SFX);
      track_done_r  <= done_nx_s;
    end
  end

  assign note_code  = note_r;
  assign note_valid = note_valid_r;
  assign cur_track  = cur_track_r;
  assign sfx_active = sfx_active_r;
  assign track_done = track_done_r;

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench for audio_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model.
module tb_audio_arbiter;

  localparam int TRACK_LEN = 16;
  localparam int SFX_LEN   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] music_req = 4'b0000;
  logic       sfx_hit = 1'b0;
  logic       sfx_miss = 1'b0;
  logic       beat_tick = 1'b0;
  logic [4:0] note_code;
  logic       note_valid;
  logic [1:0] cur_track;
  logic       sfx_active;
  logic       track_done;
  logic [9:0] obs;

  int checks = 0;
  int errors = 0;

  // Model: background context (mode 0 silent, 1 playing, 2 finished) is simply left
  // untouched while an effect runs.
  int m_mode, m_trk, m_pos, m_fx_on, m_fx_id, m_fx_left, m_note, m_done, m_pend, m_pend_trk;

  always #5 clk = ~clk;

  audio_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .music_req  (music_req),
    .sfx_hit    (sfx_hit),
    .sfx_miss   (sfx_miss),
    .beat_tick  (beat_tick),
    .note_code  (note_code),
    .note_valid (note_valid),
    .cur_track  (cur_track),
    .sfx_active (sfx_active),
    .track_done (track_done)
  );

  assign obs = {note_code, note_valid, cur_track, sfx_active, track_done};

  function automatic int rom_bg(input int t, input int i);
    return (t * 5 + i * 3 + 1) % 23;
  endfunction

  function automatic int rom_fx(input int id, input int k);
    return (id == 1) ? 8 - k : 24 + k;
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [4:0] n;
    n = 5'(m_note);
    return {n, (m_note != 0), 2'(m_trk), (m_fx_on != 0), (m_done != 0)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_trk = 0; m_pos = 0; m_fx_on = 0; m_fx_id = 0;
    m_fx_left = 0; m_note = 0; m_done = 0; m_pend = 0; m_pend_trk = -1;
  endtask

  task automatic model_bg_beat(input int allow);
    if (allow != 0 && m_pend != 0) begin
      if (m_pend_trk >= 0) begin
        m_mode = 1; m_trk = m_pend_trk; m_note = rom_bg(m_trk, 0); m_pos = 1;
      end else begin
        m_mode = 0; m_note = 0;
      end
      m_done = 0;
    end else if (m_mode == 1) begin
      if (m_trk >= 2 && m_pos == TRACK_LEN) begin
        m_mode = 2; m_note = 0; m_done = 1;
      end else begin
        m_note = rom_bg(m_trk, m_pos);
        m_pos++;
        if (m_trk < 2 && m_pos == TRACK_LEN) m_pos = 0;
        m_done = 0;
      end
    end else begin
      m_note = 0;
      m_done = (m_mode == 2) ? 1 : 0;
    end
  endtask

  task automatic model_step();
    int rq;
    int want;
    rq = -1;
    if ($countones(music_req) == 1) begin
      for (int b = 0; b < 4; b++) if (music_req[b]) rq = b;
    end
    want = sfx_miss ? 1 : (sfx_hit ? 0 : -1);
    if (want >= 0 && (m_fx_on == 0 || want >= m_fx_id)) begin
      m_fx_on = 1; m_fx_id = want; m_fx_left = SFX_LEN; m_note = rom_fx(want, 0); m_done = 0;
    end else if (beat_tick) begin
      if (m_fx_on != 0) begin
        m_fx_left--;
        if (m_fx_left > 0) begin
          m_note = rom_fx(m_fx_id, SFX_LEN - m_fx_left);
        end else begin
          m_fx_on = 0;
          model_bg_beat(0);
        end
      end else begin
        model_bg_beat(1);
      end
    end
    if (rq >= 0) m_pend = (m_mode == 0 || rq != m_trk) ? 1 : 0;
    else m_pend = (m_mode != 0) ? 1 : 0;
    m_pend_trk = rq;
  endtask

  task automatic tick(input logic h, input logic m, input logic b);
    sfx_hit = h; sfx_miss = m; beat_tick = b;
    @(posedge clk);
    model_step();
    #1;
    sfx_hit = 1'b0; sfx_miss = 1'b0; beat_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; music_req = 4'b0001;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (obs !== 10'd0) begin errors++; $display("FAIL reset_state: got %h want %h", obs, 10'd0); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_init_wrap();
    for (int i = 0; i < 18 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL init_wrap cyc %0d: got %h want %h", i, obs, exp_vec()); end
      if (i == 2 || i == 16 * 3 + 2) begin
        checks++;
        if (note_code !== 5'(rom_bg(0, 0)) || cur_track !== 2'd0) begin
          errors++; $display("FAIL init_first_note cyc %0d: got note %0d trk %0d want note %0d trk 0", i, note_code, cur_track, rom_bg(0, 0));
        end
      end
    end
  endtask

  task automatic test_win_hold();
    music_req = 4'b0100;
    tick(1'b0, 1'b0, 1'b0);
    checks++; if (cur_track !== 2'd0 || obs !== exp_vec()) begin errors++; $display("FAIL win_pending: got %h want %h", obs, exp_vec()); end
    for (int i = 0; i < 18 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL win_run cyc %0d: got %h want %h", i, obs, exp_vec()); end
      if (i == 2) begin
        checks++;
        if (cur_track !== 2'd2 || note_code !== 5'(rom_bg(2, 0))) begin
          errors++; $display("FAIL win_apply: got trk %0d note %0d want trk 2 note %0d", cur_track, note_code, rom_bg(2, 0));
        end
      end
    end
    checks++; if (track_done !== 1'b1 || note_code !== 5'd0) begin errors++; $display("FAIL win_hold: got done %b note %0d want done 1 note 0", track_done, note_code); end
  endtask

  task automatic test_hit_effect();
    music_req = 4'b0010;
    for (int i = 0; i < 5 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL play_lead cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (sfx_active !== 1'b1 || note_code !== 5'd24 || obs !== exp_vec()) begin errors++; $display("FAIL hit_start: got %h want %h", obs, exp_vec()); end
    for (int i = 0; i < 4 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL hit_run cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (sfx_active !== 1'b0 || note_code !== 5'(rom_bg(1, 5))) begin errors++; $display("FAIL hit_resume: got act %b note %0d want act 0 note %0d", sfx_active, note_code, rom_bg(1, 5)); end
  endtask

  task automatic test_priority();
    tick(1'b1, 1'b1, 1'b0);
    checks++; if (sfx_active !== 1'b1 || note_code !== 5'd8) begin errors++; $display("FAIL miss_wins: got act %b note %0d want act 1 note 8", sfx_active, note_code); end
    for (int i = 0; i < 2 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL miss_run cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (note_code !== 5'd6 || sfx_active !== 1'b1) begin errors++; $display("FAIL hit_ignored: got act %b note %0d want act 1 note 6", sfx_active, note_code); end
    for (int i = 0; i < 2 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL miss_tail cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (sfx_active !== 1'b0 || note_code !== 5'(rom_bg(1, 6))) begin errors++; $display("FAIL miss_end: got act %b note %0d want act 0 note %0d", sfx_active, note_code, rom_bg(1, 6)); end
  endtask

  task automatic test_track_during_sfx();
    tick(1'b1, 1'b0, 1'b0);
    music_req = 4'b1000;
    for (int i = 0; i < 4 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (cur_track !== 2'd1 || obs !== exp_vec()) begin errors++; $display("FAIL sfx_hold_trk cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (sfx_active !== 1'b0 || note_code !== 5'(rom_bg(1, 7))) begin errors++; $display("FAIL sfx_trk_resume: got act %b note %0d want act 0 note %0d", sfx_active, note_code, rom_bg(1, 7)); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, i == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL sfx_trk_apply cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (cur_track !== 2'd3 || note_code !== 5'(rom_bg(3, 0))) begin errors++; $display("FAIL loss_first: got trk %0d note %0d want trk 3 note %0d", cur_track, note_code, rom_bg(3, 0)); end
  endtask

  task automatic test_beat_collision();
    tick(1'b0, 1'b1, 1'b1);
    checks++; if (sfx_active !== 1'b1 || note_code !== 5'd8) begin errors++; $display("FAIL beat_sfx_start: got act %b note %0d want act 1 note 8", sfx_active, note_code); end
    for (int i = 0; i < 4 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL beat_sfx_run cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (note_code !== 5'(rom_bg(3, 1))) begin errors++; $display("FAIL beat_sfx_noskip: got note %0d want %0d", note_code, rom_bg(3, 1)); end
  endtask

  task automatic test_invalid_req();
    music_req = 4'b0110;
    for (int i = 0; i < 2 * 3; i++) begin
      tick(1'b0, 1'b0, (i % 3) == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL invalid_run cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
    checks++; if (note_valid !== 1'b0 || note_code !== 5'd0 || track_done !== 1'b0) begin errors++; $display("FAIL invalid_idle: got valid %b note %0d done %b want 0 0 0", note_valid, note_code, track_done); end
  endtask

  task automatic test_random();
    int r;
    logic h, m, b;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        music_req = (r < 8) ? (4'b0001 << (r % 4)) : 4'($urandom_range(0, 15));
      end
      h = ($urandom_range(0, 29) == 0);
      m = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 2) == 0);
      tick(h, m, b);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    music_req = 4'b0010;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    checks++; if (sfx_active !== 1'b1 || obs !== exp_vec()) begin errors++; $display("FAIL pre_reset_sfx: got %h want %h", obs, exp_vec()); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (obs !== 10'd0) begin errors++; $display("FAIL async_reset: got %h want %h", obs, 10'd0); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, i == 2);
      checks++; if (obs !== exp_vec()) begin errors++; $display("FAIL post_reset cyc %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_wrap();
    test_win_hold();
    test_hit_effect();
    test_priority();
    test_track_during_sfx();
    test_beat_collision();
    test_invalid_req();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
